cpu_obi_hart_mux: RTL

Multi-hart OBI request multiplexer for the CPU subsystem. It merges the OBI ports of NUM_HARTS cores, instruction or data side, onto one OBI manager port toward the bus. It uses round-robin arbitration, holds its selection stable while a request waits for grant, and keeps an in-order FIFO of hart indices so every response goes back to the hart that issued it. This lets the subsystem instantiate more than one core without changing the system bus.

---
 rtl/cpu_obi_hart_mux_if.sv | 50 +++++
 rtl/cpu_obi_hart_mux.sv | 112 +++++++++++
 2 files changed

// File: rtl/cpu_obi_hart_mux_if.sv
// OBI request/response types and the bundle of hart-side and bus-side
// signals that cpu_obi_hart_mux sits between.
package cpu_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

interface cpu_obi_hart_mux_if #(
    parameter int NUM_HARTS = 2
);
    import cpu_obi_pkg::*;

    obi_req_t  [NUM_HARTS-1:0] hart_req_i;
    obi_resp_t [NUM_HARTS-1:0] hart_resp_o;
    obi_req_t                  bus_req_o;
    obi_resp_t                 bus_resp_i;
    logic                      busy_o;
    logic                      err_o;

    // mux side
    modport slave (
        input  hart_req_i,
        output hart_resp_o,
        output bus_req_o,
        input  bus_resp_i,
        output busy_o,
        output err_o
    );

    // harts plus bus, seen from outside the mux
    modport master (
        output hart_req_i,
        input  hart_resp_o,
        input  bus_req_o,
        output bus_resp_i,
        input  busy_o,
        input  err_o
    );
endinterface

// File: rtl/cpu_obi_hart_mux.sv
// Round-robin OBI multiplexer merging NUM_HARTS hart ports onto one bus port,
// with an in-order FIFO of hart indices for routing responses back.
module cpu_obi_hart_mux
    import cpu_obi_pkg::*;
#(
    parameter int NUM_HARTS       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cpu_obi_hart_mux_if.slave     obi
);
    localparam int IDW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0] rr_ptr;
    logic           lock_vld;
    logic [IDW-1:0] lock_idx;
    logic [IDW-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           err;

    logic [IDW-1:0] win;
    logic           found;
    logic           full;
    logic           hs;
    logic           pop;
    logic [IDW-1:0] head;
    int             j;
    obi_req_t       bus_req;
    obi_resp_t [NUM_HARTS-1:0] resp;

    assign full = (count == CW'(MAX_OUTSTANDING));
    assign head = fifo_mem[rptr];

    // A pending, ungranted request pins the winner so its attributes stay stable.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        j     = 0;
        if (lock_vld) begin
            win   = lock_idx;
            found = obi.hart_req_i[lock_idx].req;
        end else begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                j = (int'(rr_ptr) + k) % NUM_HARTS;
                if (!found && obi.hart_req_i[j].req) begin
                    found = 1'b1;
                    win   = IDW'(j);
                end
            end
        end
    end

    always_comb begin
        bus_req     = obi.hart_req_i[win];
        bus_req.req = found & ~full & ~rst_i;
    end

    assign hs  = bus_req.req & obi.bus_resp_i.gnt;
    assign pop = obi.bus_resp_i.rvalid & (count != '0) & ~rst_i;

    always_comb begin
        resp = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            resp[i].gnt    = hs  & (win  == IDW'(i));
            resp[i].rvalid = pop & (head == IDW'(i));
            resp[i].rdata  = obi.bus_resp_i.rdata;
        end
    end

    assign obi.bus_req_o   = bus_req;
    assign obi.hart_resp_o = resp;
    assign obi.busy_o      = (count != '0);
    assign obi.err_o       = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem[i] <= '0;
        end else begin
            if (hs) begin
                fifo_mem[wptr] <= win;
                wptr     <= (wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr + 1'b1;
                rr_ptr   <= (win == IDW'(NUM_HARTS - 1)) ? '0 : win + 1'b1;
                lock_vld <= 1'b0;
            end else if (bus_req.req) begin
                lock_vld <= 1'b1;
                lock_idx <= win;
            end
            if (pop) begin
                rptr <= (rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr + 1'b1;
            end
            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A response with nothing in flight has no owner: drop it and flag.
            if (obi.bus_resp_i.rvalid && (count == '0)) err <= 1'b1;
        end
    end
endmodule
